mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Generalised N-requester arbiter and reply router for the serial memory interface.
- Replaces the hard-wired two-way prefetcher/scheduler TX mux and the reply-type FIFO.
- Selects which requester drives the TX command/data, holds ownership for a whole transaction or a reserved sequence, and records the owner of each reply-bearing command.
- Steers RX strobes back to the requester that owns the oldest outstanding reply.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 is highest priority in fixed mode.
- IO_BITS, 2: width of TX/RX data per cycle.
- CMD_BITS, 2: width of the TX command header.
- MAX_OUTSTANDING, 4: depth of the reply-owner FIFO.
- DEFAULT_REQ, 1: owner selected when no requester wants TX (the idle prefetch path).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_cmd_valid  in  NUM_REQ  per-requester command valid
- req_cmd  in  NUM_REQ*CMD_BITS  per-requester command; requester i occupies [i*CMD_BITS +: CMD_BITS]
- req_data  in  NUM_REQ*IO_BITS  per-requester TX payload; same slicing
- req_reserve  in  NUM_REQ  keep TX ownership across consecutive transactions
- req_reply_wanted  in  NUM_REQ  command expects an RX reply
- tx_command_valid  out  1  to memory interface
- tx_command  out  CMD_BITS  to memory interface
- tx_data  out  IO_BITS  to memory interface
- tx_command_started, tx_active, tx_data_next, tx_done  in  1 each  from memory interface
- rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done  in  1 each  from memory interface
- tx_owner  out  NUM_REQ  one-hot current TX owner
- g_tx_command_started, g_tx_active, g_tx_data_next, g_tx_done  out  NUM_REQ each  TX strobes ANDed with tx_owner
- rx_owner  out  NUM_REQ  one-hot owner of the FIFO head; all zero when empty
- g_rx_started, g_rx_active, g_rx_sbs_valid, g_rx_data_valid, g_rx_done  out  NUM_REQ each  RX strobes ANDed with rx_owner
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  FIFO occupancy
- full, empty  out  1 each  FIFO status
- rx_orphan  out  1  sticky; set when rx_started or rx_done arrives with the FIFO empty

Behaviour:
- Wanting TX: want[i] = req_cmd_valid[i] | req_reserve[i].
- Owner selection while tx_active=0:
  - If the registered owner has req_reserve high, it keeps ownership.
  - Otherwise the winner is the lowest index with want set.
  - If no requester wants TX, the winner is DEFAULT_REQ.
- tx_owner while tx_active=0 is the combinational winner, so a request is granted with zero latency. The owner register loads the winner every cycle that tx_active=0.
- While tx_active=1, tx_owner equals the owner register; ownership never changes mid-transaction.
- Command path:
  - tx_command and tx_data are muxed from the owner's slices.
  - tx_command_valid = req_cmd_valid[owner] & !(full & req_reply_wanted[owner]).
  - A reply-bearing command is therefore stalled, not dropped, when the FIFO is full.
- FIFO push: on tx_command_started & req_reply_wanted[owner], push the owner index (width max(1,$clog2(NUM_REQ))).
- FIFO pop: on rx_done with the FIFO non-empty.
- Push and pop in the same cycle: occupancy unchanged; the head advances.
- Push while full cannot occur because of the stall above; if it does occur, it is ignored.
- rx_owner decodes the head entry. RX strobes with the FIFO empty reach no requester and set rx_orphan.
- rx_orphan clears only on reset.
- Reset: owner register = DEFAULT_REQ, FIFO empty, outstanding=0, full=0, empty=1, rx_orphan=0, rr pointer=0.
- Reset mid-transaction discards all outstanding entries. Later RX strobes for those entries count as orphans.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - Non-reserved arbitration is round-robin: the search starts at (last granted started command index + 1) mod NUM_REQ.
  - The pointer updates on tx_command_started.
  - DEFAULT_REQ still applies when nobody wants TX.
- When undefined: fixed priority, lowest index wins, and no pointer register is built.

Test Plan:
- Single requester: req 2 valid, reply_wanted=1; pulse tx_command_started -> tx_owner=3'b100, outstanding=1, rx_owner=3'b100; rx_done -> outstanding=0, empty=1.
- Conflict: req 0 and req 2 valid with tx_active=0 -> tx_owner=3'b001. Raise tx_active, then drop req 0 valid -> owner stays 3'b001 until tx_active=0, then switches to 3'b100.
- Reservation: req 2 reserve=1 through two transactions while req 0 stays valid -> req 2 owns both. Release reserve with tx_active=0 -> owner becomes 3'b001 the same cycle.
- Full stall: issue 4 reply-bearing commands without rx_done -> full=1 and tx_command_valid=0 for a 5th. A reply_wanted=0 command still sees valid=1. One rx_done -> full=0.
- Ordering: push owners 1,0,2 -> rx_owner sequence is 010,001,100 across three rx_done. Simultaneous push and rx_done -> outstanding unchanged.
- Orphan and reset: rx_done with FIFO empty -> rx_orphan=1 and all g_rx_done=0. Reset -> rx_orphan=0, tx_owner=3'b010 when nobody wants TX. With MEM_ARB_ROUND_ROBIN_EN and all three requesters continuously valid, grants rotate 0,1,2,0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// N-requester arbiter and reply router for the serial memory interface.
// Chooses which requester drives the TX command/data, keeps that owner for a
// whole transaction (or a reserved run of transactions), and records the
// owner of every reply-bearing command in a small FIFO so RX strobes are
// steered back to whoever owns the oldest outstanding reply.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, non-reserved arbitration is
//                            round-robin starting after the last requester
//                            whose command started; otherwise fixed priority
//                            (index 0 highest) and no pointer is built.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   req_cmd_valid/req_cmd/req_data/req_reserve/req_reply_wanted
//                                 per-requester request side (sliced by index)
//   tx_command_valid/tx_command/tx_data
//                                 muxed command to the memory interface
//   tx_command_started..tx_done   TX strobes from the memory interface
//   rx_started..rx_done           RX strobes from the memory interface
//   tx_owner, g_tx_*              one-hot TX owner and gated TX strobes
//   rx_owner, g_rx_*              one-hot reply owner and gated RX strobes
//   outstanding, full, empty      reply-owner FIFO status
//   rx_orphan                     sticky: RX strobe seen with FIFO empty
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int IO_BITS         = 2,
  parameter int CMD_BITS        = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DEFAULT_REQ     = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_cmd_valid,
  input  logic [NUM_REQ*CMD_BITS-1:0]            req_cmd,
  input  logic [NUM_REQ*IO_BITS-1:0]             req_data,
  input  logic [NUM_REQ-1:0]                     req_reserve,
  input  logic [NUM_REQ-1:0]                     req_reply_wanted,
  output logic                                   tx_command_valid,
  output logic [CMD_BITS-1:0]                    tx_command,
  output logic [IO_BITS-1:0]                     tx_data,
  input  logic                                   tx_command_started,
  input  logic                                   tx_active,
  input  logic                                   tx_data_next,
  input  logic                                   tx_done,
  input  logic                                   rx_started,
  input  logic                                   rx_active,
  input  logic                                   rx_sbs_valid,
  input  logic                                   rx_data_valid,
  input  logic                                   rx_done,
  output logic [NUM_REQ-1:0]                     tx_owner,
  output logic [NUM_REQ-1:0]                     g_tx_command_started,
  output logic [NUM_REQ-1:0]                     g_tx_active,
  output logic [NUM_REQ-1:0]                     g_tx_data_next,
  output logic [NUM_REQ-1:0]                     g_tx_done,
  output logic [NUM_REQ-1:0]                     rx_owner,
  output logic [NUM_REQ-1:0]                     g_rx_started,
  output logic [NUM_REQ-1:0]                     g_rx_active,
  output logic [NUM_REQ-1:0]                     g_rx_sbs_valid,
  output logic [NUM_REQ-1:0]                     g_rx_data_valid,
  output logic [NUM_REQ-1:0]                     g_rx_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   rx_orphan
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic logic [NUM_REQ-1:0] to_onehot(input idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) oh[i] = (idx == idx_t'(i));
    return oh;
  endfunction

  // FIFO depth need not be a power of two, so wrap explicitly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Owner selection
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] want;
  idx_t               owner_q;
  idx_t               win_idx;
  idx_t               owner_idx;
  logic               found;
  logic               hold_reserve;

  assign want         = req_cmd_valid | req_reserve;
  assign hold_reserve = |(req_reserve & to_onehot(owner_q));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  idx_t rr_ptr;
  int   rr_cand;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_idx = idx_t'(DEFAULT_REQ);
    found   = 1'b0;
    rr_cand = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && want[rr_cand]) begin
        win_idx = idx_t'(rr_cand);
        found   = 1'b1;
      end
    end
    if (hold_reserve) win_idx = owner_q;
  end

  // Next search starts just after the requester whose command went out.
  always_ff @(posedge clk) begin
    if (reset)                   rr_ptr <= '0;
    else if (tx_command_started) rr_ptr <= (owner_idx == idx_t'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;
  end
`else
  // NOTE: every combinational output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    win_idx = idx_t'(DEFAULT_REQ);
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && want[i]) begin
        win_idx = idx_t'(i);
        found   = 1'b1;
      end
    end
    if (hold_reserve) win_idx = owner_q;
  end
`endif

  // Zero-latency grant between transactions; frozen while one is in flight.
  assign owner_idx = tx_active ? owner_q : win_idx;
  assign tx_owner  = to_onehot(owner_idx);

  // ---------------------------------------------------------------------------
  // Command path
  // ---------------------------------------------------------------------------
  logic owner_valid;
  logic owner_reply;

  always_comb begin
    tx_command = '0;
    tx_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tx_owner[i]) begin
        tx_command = req_cmd[i*CMD_BITS +: CMD_BITS];
        tx_data    = req_data[i*IO_BITS +: IO_BITS];
      end
    end
  end

  assign owner_valid = |(req_cmd_valid & tx_owner);
  assign owner_reply = |(req_reply_wanted & tx_owner);
  // A reply-bearing command waits while the FIFO is full instead of being lost.
  assign tx_command_valid = owner_valid & ~(full & owner_reply);

  assign g_tx_command_started = {NUM_REQ{tx_command_started}} & tx_owner;
  assign g_tx_active          = {NUM_REQ{tx_active}}          & tx_owner;
  assign g_tx_data_next       = {NUM_REQ{tx_data_next}}       & tx_owner;
  assign g_tx_done            = {NUM_REQ{tx_done}}            & tx_owner;

  // ---------------------------------------------------------------------------
  // Reply-owner FIFO
  // ---------------------------------------------------------------------------
  idx_t             fifo_mem [MAX_OUTSTANDING];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign push = tx_command_started & owner_reply & ~full;
  assign pop  = rx_done & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= idx_t'(DEFAULT_REQ);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_orphan <= 1'b0;
    end else begin
      if (!tx_active) owner_q <= win_idx;
      if (push)       wr_ptr  <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr  <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if ((rx_started | rx_done) & empty) rx_orphan <= 1'b1;
    end
  end

  // NOTE: entry storage has no reset; the pointers and count alone decide
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= owner_idx;
  end

  assign outstanding = count;
  assign full        = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty       = (count == '0);
  assign rx_owner    = empty ? '0 : to_onehot(fifo_mem[rd_ptr]);

  assign g_rx_started    = {NUM_REQ{rx_started}}    & rx_owner;
  assign g_rx_active     = {NUM_REQ{rx_active}}     & rx_owner;
  assign g_rx_sbs_valid  = {NUM_REQ{rx_sbs_valid}}  & rx_owner;
  assign g_rx_data_valid = {NUM_REQ{rx_data_valid}} & rx_owner;
  assign g_rx_done       = {NUM_REQ{rx_done}}       & rx_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (NUM_REQ=3, IO_BITS=2, CMD_BITS=2,
// MAX_OUTSTANDING=4, DEFAULT_REQ=1). Stimulus pushes expected values into
// queues; a monitor running on the falling edge pops and compares them, and
// checks reply routing whenever the DUT sees rx_done with replies expected.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NUM_REQ = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req_cmd_valid, req_reserve, req_reply_wanted;
  logic [5:0] req_cmd, req_data;
  logic       tx_command_valid;
  logic [1:0] tx_command, tx_data;
  logic       tx_command_started, tx_active, tx_data_next, tx_done;
  logic       rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done;
  logic [2:0] tx_owner, g_tx_command_started, g_tx_active, g_tx_data_next, g_tx_done;
  logic [2:0] rx_owner, g_rx_started, g_rx_active, g_rx_sbs_valid, g_rx_data_valid, g_rx_done;
  logic [2:0] outstanding;
  logic       full, empty, rx_orphan;

  mem_port_arbiter #(
    .NUM_REQ(3), .IO_BITS(2), .CMD_BITS(2), .MAX_OUTSTANDING(4), .DEFAULT_REQ(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_cmd_valid(req_cmd_valid), .req_cmd(req_cmd), .req_data(req_data),
    .req_reserve(req_reserve), .req_reply_wanted(req_reply_wanted),
    .tx_command_valid(tx_command_valid), .tx_command(tx_command), .tx_data(tx_data),
    .tx_command_started(tx_command_started), .tx_active(tx_active),
    .tx_data_next(tx_data_next), .tx_done(tx_done),
    .rx_started(rx_started), .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done),
    .tx_owner(tx_owner), .g_tx_command_started(g_tx_command_started),
    .g_tx_active(g_tx_active), .g_tx_data_next(g_tx_data_next), .g_tx_done(g_tx_done),
    .rx_owner(rx_owner), .g_rx_started(g_rx_started), .g_rx_active(g_rx_active),
    .g_rx_sbs_valid(g_rx_sbs_valid), .g_rx_data_valid(g_rx_data_valid),
    .g_rx_done(g_rx_done),
    .outstanding(outstanding), .full(full), .empty(empty), .rx_orphan(rx_orphan)
  );

  always #5 clk = ~clk;

  typedef enum {
    S_TX_OWNER, S_TX_VALID, S_TX_CMD, S_TX_DATA, S_G_TX_STARTED,
    S_RX_OWNER, S_G_RX_DONE, S_OUTSTANDING, S_FULL, S_EMPTY, S_ORPHAN
  } sig_e;

  typedef struct {
    string      name;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] reply_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic logic [7:0] sample(input sig_e s);
    case (s)
      S_TX_OWNER:     return 8'(tx_owner);
      S_TX_VALID:     return 8'(tx_command_valid);
      S_TX_CMD:       return 8'(tx_command);
      S_TX_DATA:      return 8'(tx_data);
      S_G_TX_STARTED: return 8'(g_tx_command_started);
      S_RX_OWNER:     return 8'(rx_owner);
      S_G_RX_DONE:    return 8'(g_rx_done);
      S_OUTSTANDING:  return 8'(outstanding);
      S_FULL:         return 8'(full);
      S_EMPTY:        return 8'(empty);
      default:        return 8'(rx_orphan);
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input string name, input sig_e s, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: drain tagged expectations and check reply routing on rx_done.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, sample(e.sig), e.val);
    end
    if (rx_done && reply_q.size() > 0) begin
      logic [2:0] r;
      r = reply_q.pop_front();
      check("reply_rx_owner", 8'(rx_owner), 8'(r));
      check("reply_g_rx_done", 8'(g_rx_done), 8'(r));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_cmd_valid = '0; req_reserve = '0; req_reply_wanted = '0;
    tx_command_started = 0; tx_active = 0; tx_data_next = 0; tx_done = 0;
    rx_started = 0; rx_active = 0; rx_sbs_valid = 0; rx_data_valid = 0; rx_done = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    reply_q.delete();
  endtask

  // One reply-bearing command from a single requester (one-hot r).
  task automatic issue_reply(input logic [2:0] r);
    req_cmd_valid = r; req_reply_wanted = r; tx_command_started = 1'b1;
    reply_q.push_back(r);
    tick();
    tx_command_started = 1'b0; req_cmd_valid = '0; req_reply_wanted = '0;
  endtask

  initial begin
    logic [2:0] rot [4];
    idle_inputs();
    req_cmd  = 6'b11_00_01;
    req_data = 6'b10_00_01;
    do_reset();

    // Reset state
    exp_push("rst_tx_owner", S_TX_OWNER, 8'b010);
    exp_push("rst_outstanding", S_OUTSTANDING, 0);
    exp_push("rst_empty", S_EMPTY, 1);
    exp_push("rst_full", S_FULL, 0);
    exp_push("rst_orphan", S_ORPHAN, 0);
    exp_push("rst_rx_owner", S_RX_OWNER, 0);
    exp_push("rst_tx_valid", S_TX_VALID, 0);
    tick();

    // Single requester
    req_cmd_valid = 3'b100; req_reply_wanted = 3'b100;
    exp_push("single_owner", S_TX_OWNER, 8'b100);
    exp_push("single_valid", S_TX_VALID, 1);
    exp_push("single_cmd", S_TX_CMD, 3);
    exp_push("single_data", S_TX_DATA, 2);
    tick();
    tx_command_started = 1'b1;
    reply_q.push_back(3'b100);
    exp_push("single_g_started", S_G_TX_STARTED, 8'b100);
    tick();
    idle_inputs();
    exp_push("single_outstanding", S_OUTSTANDING, 1);
    exp_push("single_rx_owner", S_RX_OWNER, 8'b100);
    exp_push("single_idle_owner", S_TX_OWNER, 8'b010);
    tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    exp_push("single_drained", S_OUTSTANDING, 0);
    exp_push("single_empty", S_EMPTY, 1);
    tick();

    // Conflict: req 0 beats req 2, ownership frozen while tx_active
    req_cmd_valid = 3'b101;
    exp_push("conflict_owner", S_TX_OWNER, 8'b001);
    exp_push("conflict_cmd", S_TX_CMD, 1);
    tick();
    tx_active = 1'b1; tx_command_started = 1'b1;
    exp_push("conflict_start", S_TX_OWNER, 8'b001);
    tick();
    tx_command_started = 1'b0; req_cmd_valid = 3'b100;
    exp_push("conflict_hold1", S_TX_OWNER, 8'b001);
    tick();
    exp_push("conflict_hold2", S_TX_OWNER, 8'b001);
    tick();
    tx_active = 1'b0;
    exp_push("conflict_switch", S_TX_OWNER, 8'b100);
    tick();
    idle_inputs();
    tick();

    // Reservation: req 2 keeps TX across two transactions despite req 0
    req_cmd_valid = 3'b100; req_reserve = 3'b100;
    tick();
    req_cmd_valid = 3'b101;
    exp_push("resv_grab", S_TX_OWNER, 8'b100);
    for (int t = 0; t < 2; t++) begin
      tx_active = 1'b1; tx_command_started = 1'b1;
      tick();
      tx_command_started = 1'b0;
      exp_push("resv_active", S_TX_OWNER, 8'b100);
      tick();
      tx_active = 1'b0;
      exp_push("resv_between", S_TX_OWNER, 8'b100);
      tick();
    end
    req_reserve = 3'b000;
    exp_push("resv_release", S_TX_OWNER, 8'b001);
    tick();
    idle_inputs();
    tick();

    // Full stall with requester 1
    for (int i = 0; i < 4; i++) begin
      exp_push("fill_valid", S_TX_VALID, 1);
      issue_reply(3'b010);
    end
    req_cmd_valid = 3'b010; req_reply_wanted = 3'b010;
    exp_push("full_flag", S_FULL, 1);
    exp_push("full_count", S_OUTSTANDING, 4);
    exp_push("full_stall", S_TX_VALID, 0);
    tick();
    req_reply_wanted = 3'b000;
    exp_push("full_noreply_valid", S_TX_VALID, 1);
    tick();
    req_reply_wanted = 3'b010; tx_command_started = 1'b1;  // ignored push
    tick();
    tx_command_started = 1'b0;
    exp_push("full_ignored_push", S_OUTSTANDING, 4);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    exp_push("unfull_flag", S_FULL, 0);
    exp_push("unfull_count", S_OUTSTANDING, 3);
    exp_push("unfull_valid", S_TX_VALID, 1);
    tick();
    idle_inputs();
    rx_done = 1'b1;
    tick();
    tick();
    tick();
    rx_done = 1'b0;
    exp_push("drain_empty", S_EMPTY, 1);
    tick();

    // Ordering 1,0,2 then simultaneous push/pop
    issue_reply(3'b010);
    issue_reply(3'b001);
    issue_reply(3'b100);
    exp_push("order_count", S_OUTSTANDING, 3);
    exp_push("order_head", S_RX_OWNER, 8'b010);
    rx_done = 1'b1;
    tick();
    tick();
    tick();
    rx_done = 1'b0;
    issue_reply(3'b001);
    req_cmd_valid = 3'b100; req_reply_wanted = 3'b100; tx_command_started = 1'b1;
    reply_q.push_back(3'b100);
    rx_done = 1'b1;
    tick();
    idle_inputs();
    exp_push("pushpop_count", S_OUTSTANDING, 1);
    exp_push("pushpop_head", S_RX_OWNER, 8'b100);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    exp_push("pushpop_empty", S_EMPTY, 1);
    exp_push("pre_orphan", S_ORPHAN, 0);
    tick();

    // Orphan, then reset mid-flight
    rx_done = 1'b1;
    exp_push("orphan_g_rx_done", S_G_RX_DONE, 0);
    exp_push("orphan_rx_owner", S_RX_OWNER, 0);
    tick();
    rx_done = 1'b0;
    exp_push("orphan_set", S_ORPHAN, 1);
    tick();
    req_cmd_valid = 3'b100; req_reply_wanted = 3'b100; tx_command_started = 1'b1;
    tick();
    idle_inputs();
    do_reset();
    exp_push("rst2_orphan", S_ORPHAN, 0);
    exp_push("rst2_tx_owner", S_TX_OWNER, 8'b010);
    exp_push("rst2_outstanding", S_OUTSTANDING, 0);
    rx_done = 1'b1;
    exp_push("rst2_g_rx_done", S_G_RX_DONE, 0);
    tick();
    rx_done = 1'b0;
    exp_push("rst2_orphan_again", S_ORPHAN, 1);
    tick();

    // All three continuously valid: rotation or fixed priority
    do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100; rot[3] = 3'b001;
`else
    rot[0] = 3'b001; rot[1] = 3'b001; rot[2] = 3'b001; rot[3] = 3'b001;
`endif
    req_cmd_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_push("arb_all_valid", S_TX_OWNER, 8'(rot[k]));
      tx_command_started = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    tick();

    check("exp_queue_drained", 8'(exp_q.size()), 0);
    check("reply_queue_drained", 8'(reply_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
